termometer_multi: RTL and testbench
===================================

Name: termometer_multi

Overview:
- Parametrised successor of the single-sensor DS18B20 controller. It polls up to NUM_SENSORS temperature sensors sharing one 1-Wire bus.
- Sits directly above the byte-level one_wire core and drives its ResetN/W/R/InData handshake through the ow_* ports.
- Each round does one broadcast SKIP_ROM + CONVERT_T, waits the conversion time, then reads each sensor's 9-byte scratchpad using MATCH_ROM and checks it with CRC-8.
- Publishes one 16-bit raw temperature word per sensor, plus valid and CRC-error flags.

Parameters:
- NUM_SENSORS, 2, number of addressed sensors (1..8).
- CONV_WAIT_CYCLES, 750000, clk cycles waited after CONVERT_T completes (750 ms at 1 MHz).
- ROM_IDS, 0, packed 64-bit ROM codes; sensor i occupies bits [64*i+63:64*i].

Ports:
- clk  in  1  system clock.
- ARstN  in  1  asynchronous active-low reset.
- En  in  1  start/continue polling; sampled only in IDLE.
- ow_busy  in  1  one_wire Busy.
- ow_presence  in  1  one_wire Presence.
- ow_dout  in  8  one_wire OutData (read byte).
- ow_din  out  8  one_wire InData (byte to write).
- ow_reset_n  out  1  one_wire ResetN; active-low one-cycle strobe.
- ow_w  out  1  write strobe.
- ow_r  out  1  read strobe.
- temp  out  16*NUM_SENSORS  raw scratchpad bytes 1:0 per sensor.
- valid  out  NUM_SENSORS  temp[i] holds a CRC-good reading.
- crc_err  out  NUM_SENSORS  last read of sensor i failed CRC or presence.
- no_presence  out  1  broadcast reset saw no device.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at end of each round.

Behaviour:
- Reset (ARstN low, asynchronous):
  - All state returns to IDLE.
  - ow_reset_n=1; ow_w=0; ow_r=0; ow_din=0.
  - temp=0; valid=0; crc_err=0; no_presence=0; busy=0; done=0; counters=0.
  - Reset takes effect mid-transaction with no completion; the next round starts from scratch.
- Bus operation primitive (OP), shared by every step:
  - Assert exactly one strobe for one cycle: ow_reset_n=0, ow_w=1 with ow_din valid, or ow_r=1.
  - Wait until ow_busy is high, then wait until ow_busy is low.
  - The op completes in the cycle ow_busy is first sampled low after being high.
  - Read data (ow_dout) is captured in that cycle.
  - ow_din stays stable from the strobe until the op completes.
  - Only one strobe is active at a time.
- State sequence:
  - IDLE: En=1 -> BRESET.
  - BRESET: OP reset.
    - ow_presence=0 -> no_presence=1, go to DONE.
    - Otherwise no_presence=0, go to BSKIP.
  - BSKIP: OP write 0xCC -> BCONV.
  - BCONV: OP write 0x44 -> CWAIT.
  - CWAIT: count exactly CONV_WAIT_CYCLES cycles, starting the cycle after BCONV completes. Sensor index i=0 -> SRESET.
  - SRESET: OP reset.
    - ow_presence=0 -> valid[i]=0, crc_err[i]=1, temp[i] unchanged, go to NEXT.
    - Otherwise -> SMATCH.
  - SMATCH: OP write 0x55 -> SROM.
  - SROM: 8 OP writes of ROM_IDS sensor i, byte 0 (bits 7:0) first -> SCMD.
  - SCMD: OP write 0xBE; CRC register=0 -> SREAD.
  - SREAD: 9 OP reads.
    - Every byte is fed LSB-first into the Dallas CRC-8 (x^8+x^5+x^4+1, reflected 0x8C).
    - Bytes 0 and 1 go to a holding register.
    - After byte 8 -> SCHECK.
  - SCHECK:
    - CRC==0 -> temp[i]={byte1,byte0}, valid[i]=1, crc_err[i]=0.
    - Else temp[i] and valid[i] unchanged, crc_err[i]=1.
  - NEXT: i==NUM_SENSORS-1 -> DONE; else i+1 -> SRESET.
  - DONE: done=1 for one cycle -> IDLE.
- Outputs: temp, valid and crc_err change only in SCHECK or SRESET-fail, and only for index i.
- En:
  - En falling mid-round does not abort the round.
  - En held high starts a new round the cycle after IDLE is entered.
- No sign or scale conversion: temp carries raw two's-complement sixteenths of a degree Celsius.
- Counter widths: at least clog2(CONV_WAIT_CYCLES+1). The byte counter saturates at 9. No wrap occurs.

Test Plan:
- NUM_SENSORS=2, CONV_WAIT_CYCLES=10, bench one_wire model (Busy 3 cycles), En=1 for one round.
  - Sensor0 scratchpad 50 05 4B 46 7F FF 0C 10 1C -> temp[15:0]=0x0550, valid[0]=1, crc_err[0]=0.
  - Sensor1 carries 0xFF5E with bench-computed CRC -> temp[31:16]=0xFF5E, valid=2'b11.
  - done pulses once.
- Write-byte order on ow_din -> CC, 44, 55, ROM0 bytes LSB first, BE, then 55, ROM1 bytes, BE. Exactly 9 ow_r strobes per sensor.
- Second round with sensor1's byte 8 corrupted -> crc_err[1]=1, valid[1]=1, temp[31:16] still 0xFF5E.
- ow_presence=0 on broadcast reset -> no_presence=1, no ow_w/ow_r strobes, done pulse about 5 cycles later. Presence missing only on sensor0's reset -> valid[0]=0, crc_err[0]=1, sensor1 still read.
- Cycle count -> exactly 10 cycles between the 0x44 op completing and the SRESET ow_reset_n strobe.
- ARstN pulled low in CWAIT and in SREAD byte 4 -> outputs reach reset values immediately (combinationally asynchronous), no strobes while low. After release with En=1, the round restarts at BRESET.

Source files
------------

// File: rtl/termometer_multi.sv
// DS18B20 multi-sensor poller driving a byte-level one_wire core: broadcast
// SKIP_ROM + CONVERT_T, then a CRC-checked scratchpad read of each sensor via MATCH_ROM.
module termometer_multi #(
    parameter int                        NUM_SENSORS      = 2,
    parameter int                        CONV_WAIT_CYCLES = 750000,
    parameter logic [64*NUM_SENSORS-1:0] ROM_IDS          = '0
) (
    input  logic                       clk,
    input  logic                       ARstN,
    input  logic                       En,
    input  logic                       ow_busy,
    input  logic                       ow_presence,
    input  logic [7:0]                 ow_dout,
    output logic [7:0]                 ow_din,
    output logic                       ow_reset_n,
    output logic                       ow_w,
    output logic                       ow_r,
    output logic [16*NUM_SENSORS-1:0]  temp,
    output logic [NUM_SENSORS-1:0]     valid,
    output logic [NUM_SENSORS-1:0]     crc_err,
    output logic                       no_presence,
    output logic                       busy,
    output logic                       done
);
    localparam int CW = $clog2(CONV_WAIT_CYCLES + 1);
    localparam int IW = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;

    localparam logic [7:0] CMD_SKIP  = 8'hCC;
    localparam logic [7:0] CMD_CONV  = 8'h44;
    localparam logic [7:0] CMD_MATCH = 8'h55;
    localparam logic [7:0] CMD_READ  = 8'hBE;

    typedef enum logic [3:0] {
        S_IDLE, S_BRESET, S_BSKIP, S_BCONV, S_CWAIT, S_SRESET, S_SMATCH,
        S_SROM, S_SCMD, S_SREAD, S_SCHECK, S_NEXT, S_DONE
    } state_t;

    state_t                     state_q;
    logic                       busy_seen_q;
    logic [CW-1:0]              wait_q;
    logic [IW-1:0]              idx_q;
    logic [3:0]                 bcnt_q;
    logic [7:0]                 crc_q;
    logic [15:0]                hold_q;
    logic [7:0]                 din_q;
    logic                       rstn_q;
    logic                       w_q;
    logic                       r_q;
    logic [16*NUM_SENSORS-1:0]  temp_q;
    logic [NUM_SENSORS-1:0]     valid_q;
    logic [NUM_SENSORS-1:0]     crc_err_q;
    logic                       nop_q;
    logic                       done_q;
    logic                       op_done;

    // Dallas/Maxim CRC-8, data shifted in LSB first.
    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c;
        for (int k = 0; k < 8; k++) begin
            if (r[0] ^ d[k]) r = (r >> 1) ^ 8'h8C;
            else             r = r >> 1;
        end
        return r;
    endfunction

    function automatic logic [7:0] rom_byte(input int s, input int b);
        logic [64*NUM_SENSORS-1:0] v;
        v = ROM_IDS >> (64 * s + 8 * b);
        return v[7:0];
    endfunction

    // An op finishes on the first low sample of ow_busy after it was seen high.
    assign op_done = busy_seen_q && !ow_busy;

    // Every strobe is launched on the transition into its state, so it is
    // visible for exactly the first cycle the op state is occupied.
    always_ff @(posedge clk or negedge ARstN) begin
        if (!ARstN) begin
            state_q     <= S_IDLE;
            busy_seen_q <= 1'b0;
            wait_q      <= '0;
            idx_q       <= '0;
            bcnt_q      <= '0;
            crc_q       <= '0;
            hold_q      <= '0;
            din_q       <= '0;
            rstn_q      <= 1'b1;
            w_q         <= 1'b0;
            r_q         <= 1'b0;
            temp_q      <= '0;
            valid_q     <= '0;
            crc_err_q   <= '0;
            nop_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            rstn_q <= 1'b1;
            w_q    <= 1'b0;
            r_q    <= 1'b0;
            done_q <= 1'b0;
            if (ow_busy) busy_seen_q <= 1'b1;

            case (state_q)
                S_IDLE: if (En) begin
                    state_q <= S_BRESET; rstn_q <= 1'b0; busy_seen_q <= 1'b0;
                end
                S_BRESET: if (op_done) begin
                    if (!ow_presence) begin
                        nop_q <= 1'b1; state_q <= S_DONE; done_q <= 1'b1;
                    end else begin
                        nop_q <= 1'b0; state_q <= S_BSKIP;
                        w_q <= 1'b1; din_q <= CMD_SKIP; busy_seen_q <= 1'b0;
                    end
                end
                S_BSKIP: if (op_done) begin
                    state_q <= S_BCONV;
                    w_q <= 1'b1; din_q <= CMD_CONV; busy_seen_q <= 1'b0;
                end
                S_BCONV: if (op_done) begin
                    state_q <= S_CWAIT; wait_q <= '0;
                end
                S_CWAIT: begin
                    if (wait_q >= CW'(CONV_WAIT_CYCLES - 1)) begin
                        state_q <= S_SRESET; idx_q <= '0;
                        rstn_q <= 1'b0; busy_seen_q <= 1'b0;
                    end else begin
                        wait_q <= wait_q + CW'(1);
                    end
                end
                S_SRESET: if (op_done) begin
                    if (!ow_presence) begin
                        valid_q[idx_q] <= 1'b0; crc_err_q[idx_q] <= 1'b1;
                        state_q <= S_NEXT;
                    end else begin
                        state_q <= S_SMATCH;
                        w_q <= 1'b1; din_q <= CMD_MATCH; busy_seen_q <= 1'b0;
                    end
                end
                S_SMATCH: if (op_done) begin
                    state_q <= S_SROM; bcnt_q <= '0;
                    w_q <= 1'b1; din_q <= rom_byte(int'(idx_q), 0); busy_seen_q <= 1'b0;
                end
                S_SROM: if (op_done) begin
                    busy_seen_q <= 1'b0;
                    w_q         <= 1'b1;
                    if (bcnt_q == 4'd7) begin
                        state_q <= S_SCMD; din_q <= CMD_READ;
                    end else begin
                        bcnt_q <= bcnt_q + 4'd1;
                        din_q  <= rom_byte(int'(idx_q), int'(bcnt_q) + 1);
                    end
                end
                S_SCMD: if (op_done) begin
                    state_q <= S_SREAD; crc_q <= '0; bcnt_q <= '0;
                    r_q <= 1'b1; busy_seen_q <= 1'b0;
                end
                S_SREAD: if (op_done) begin
                    crc_q <= crc8(crc_q, ow_dout);
                    if (bcnt_q == 4'd0) hold_q[7:0]  <= ow_dout;
                    if (bcnt_q == 4'd1) hold_q[15:8] <= ow_dout;
                    if (bcnt_q != 4'd9) bcnt_q <= bcnt_q + 4'd1;
                    if (bcnt_q == 4'd8) begin
                        state_q <= S_SCHECK;
                    end else begin
                        r_q <= 1'b1; busy_seen_q <= 1'b0;
                    end
                end
                S_SCHECK: begin
                    if (crc_q == 8'h00) begin
                        temp_q[16*int'(idx_q) +: 16] <= hold_q;
                        valid_q[idx_q]   <= 1'b1;
                        crc_err_q[idx_q] <= 1'b0;
                    end else begin
                        crc_err_q[idx_q] <= 1'b1;
                    end
                    state_q <= S_NEXT;
                end
                S_NEXT: begin
                    if (idx_q == IW'(NUM_SENSORS - 1)) begin
                        state_q <= S_DONE; done_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + IW'(1); state_q <= S_SRESET;
                        rstn_q <= 1'b0; busy_seen_q <= 1'b0;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ow_din      = din_q;
    assign ow_reset_n  = rstn_q;
    assign ow_w        = w_q;
    assign ow_r        = r_q;
    assign temp        = temp_q;
    assign valid       = valid_q;
    assign crc_err     = crc_err_q;
    assign no_presence = nop_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;

endmodule

// File: tb/tb_termometer_multi.sv
// Bench for termometer_multi: behavioural one_wire core, bus-event scoreboard,
// table of polling rounds plus asynchronous-reset sequences.
`timescale 1ns/1ps
module tb_termometer_multi;
    localparam int NS   = 2;
    localparam int CONV = 10;
    localparam logic [127:0] ROMS = {64'hA200000B3C715E28, 64'h3F00000A91221128};
    localparam logic [1:0] K_RST = 2'd0, K_WR = 2'd1, K_RD = 2'd2;

    logic        clk = 1'b0, ARstN = 1'b0, En = 1'b0;
    logic        ow_busy, ow_presence, ow_reset_n, ow_w, ow_r;
    logic [7:0]  ow_dout, ow_din;
    logic [31:0] temp;
    logic [1:0]  valid, crc_err;
    logic        no_presence, busy, done;

    termometer_multi #(.NUM_SENSORS(NS), .CONV_WAIT_CYCLES(CONV), .ROM_IDS(ROMS)) dut (
        .clk(clk), .ARstN(ARstN), .En(En), .ow_busy(ow_busy), .ow_presence(ow_presence),
        .ow_dout(ow_dout), .ow_din(ow_din), .ow_reset_n(ow_reset_n), .ow_w(ow_w), .ow_r(ow_r),
        .temp(temp), .valid(valid), .crc_err(crc_err), .no_presence(no_presence),
        .busy(busy), .done(done));

    always #5 clk = ~clk;

    int n_checks = 0, n_errs = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    // one_wire core model: Busy for 3 cycles after any strobe.
    logic [7:0] spad [NS][9];
    logic [2:0] pres_cfg;            // bit0 broadcast, bit1 sensor0, bit2 sensor1
    int         busy_cnt, rst_cnt, rd_byte;
    logic       pres_q;
    logic [7:0] dout_q;
    assign ow_busy     = (busy_cnt != 0);
    assign ow_presence = pres_q;
    assign ow_dout     = dout_q;

    always @(posedge clk or negedge ARstN) begin
        if (!ARstN) begin
            busy_cnt <= 0; rst_cnt <= 0; rd_byte <= 0; pres_q <= 1'b0; dout_q <= 8'h00;
        end else begin
            if (!ow_reset_n || ow_w || ow_r) busy_cnt <= 3;
            else if (busy_cnt != 0)          busy_cnt <= busy_cnt - 1;
            if (!ow_reset_n) begin
                pres_q <= (rst_cnt < 3) ? pres_cfg[rst_cnt] : 1'b0;
                rst_cnt <= rst_cnt + 1; rd_byte <= 0;
            end
            if (ow_r && rd_byte < 9) begin
                dout_q  <= spad[(rst_cnt - 2) & 1][rd_byte];
                rd_byte <= rd_byte + 1;
            end
            if (done) rst_cnt <= 0;
        end
    end

    typedef struct packed { logic [1:0] kind; logic [7:0] data; } ev_t;
    ev_t exp_q[$];
    int  ncyc = 0, t44 = 0, gap_meas = -1, rst_t = 0, done_gap = 0, rd_seen = 0, done_cnt = 0;
    bit  arm44 = 0, bhi = 0, t44_set = 0;

    // Bus monitor: pops the scoreboard on every strobe, sampled mid-cycle.
    initial begin : monitor
        logic [1:0] k;
        int         nstb;
        ev_t        e;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!ARstN) begin
                check("quiet_in_reset", {29'd0, ow_reset_n, ow_w, ow_r}, 32'h4);
            end else begin
                nstb = int'(!ow_reset_n) + int'(ow_w) + int'(ow_r);
                if (nstb != 0) begin
                    check("strobe_onehot", nstb, 1);
                    k = !ow_reset_n ? K_RST : (ow_w ? K_WR : K_RD);
                    if (exp_q.size() == 0) begin
                        check("bus_unexpected_kind", {30'd0, k}, 32'h3);
                    end else begin
                        e = exp_q.pop_front();
                        check("bus_kind", {30'd0, k}, {30'd0, e.kind});
                        if (k == K_WR) check("bus_byte", {24'd0, ow_din}, {24'd0, e.data});
                    end
                    if (k == K_RST) begin
                        rd_seen = 0; rst_t = ncyc;
                        if (t44_set) begin gap_meas = ncyc - t44 - 1; t44_set = 0; end
                    end
                    if (k == K_RD) rd_seen++;
                    if (k == K_WR && ow_din == 8'h44) begin arm44 = 1; bhi = 0; end
                end
                if (arm44) begin
                    if (ow_busy) bhi = 1;
                    else if (bhi) begin t44 = ncyc; t44_set = 1; arm44 = 0; end
                end
                if (done) begin done_cnt++; done_gap = ncyc - rst_t; end
            end
        end
    end

    typedef struct {
        logic [2:0]  pres;
        logic [15:0] t0, t1;
        logic [1:0]  bad;
        logic [31:0] e_temp;
        logic [1:0]  e_valid, e_crc;
        logic        e_nop;
    } vec_t;

    function automatic logic [7:0] ref_crc(input logic [7:0] b [9], input int n);
        logic [7:0] c = 8'h00;
        logic       fb;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ b[i][j];
                c  = {1'b0, c[7:1]};
                if (fb) c = c ^ 8'h8C;
            end
        return c;
    endfunction

    // Build both scratchpads and queue the full expected bus sequence.
    task automatic load(input vec_t v);
        logic [7:0]   b [9];
        logic [15:0]  t;
        logic [127:0] roms_v;
        roms_v = ROMS;
        for (int s = 0; s < NS; s++) begin
            t = (s == 0) ? v.t0 : v.t1;
            b[0] = t[7:0]; b[1] = t[15:8]; b[2] = 8'h4B; b[3] = 8'h46;
            b[4] = 8'h7F;  b[5] = 8'hFF;   b[6] = 8'h0C; b[7] = 8'h10;
            b[8] = ref_crc(b, 8) ^ (v.bad[s] ? 8'h01 : 8'h00);
            for (int i = 0; i < 9; i++) spad[s][i] = b[i];
        end
        pres_cfg = v.pres;
        exp_q.delete();
        exp_q.push_back('{K_RST, 8'h00});
        if (v.pres[0]) begin
            exp_q.push_back('{K_WR, 8'hCC});
            exp_q.push_back('{K_WR, 8'h44});
            for (int s = 0; s < NS; s++) begin
                exp_q.push_back('{K_RST, 8'h00});
                if (v.pres[s+1]) begin
                    exp_q.push_back('{K_WR, 8'h55});
                    for (int i = 0; i < 8; i++) exp_q.push_back('{K_WR, roms_v[64*s + 8*i +: 8]});
                    exp_q.push_back('{K_WR, 8'hBE});
                    for (int i = 0; i < 9; i++) exp_q.push_back('{K_RD, 8'h00});
                end
            end
        end
    endtask

    task automatic wait_done(input int d0, input string name);
        for (int c = 0; c < 2000 && done_cnt == d0; c++) @(negedge clk);
        check({name, "_done"}, done_cnt - d0, 1);
        repeat (3) @(negedge clk);
        check({name, "_done_once"}, done_cnt - d0, 1);
        check({name, "_queue_drained"}, exp_q.size(), 0);
        check({name, "_busy_idle"}, {31'd0, busy}, 0);
    endtask

    task automatic check_outputs(input vec_t v, input string name);
        check({name, "_temp"}, temp, v.e_temp);
        check({name, "_valid"}, {30'd0, valid}, {30'd0, v.e_valid});
        check({name, "_crc_err"}, {30'd0, crc_err}, {30'd0, v.e_crc});
        check({name, "_no_presence"}, {31'd0, no_presence}, {31'd0, v.e_nop});
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_rst_temp"}, temp, 0);
        check({name, "_rst_flags"}, {26'd0, valid, crc_err, no_presence, done}, 0);
        check({name, "_rst_busy"}, {31'd0, busy}, 0);
        check({name, "_rst_strobes"}, {29'd0, ow_reset_n, ow_w, ow_r}, 32'h4);
        check({name, "_rst_din"}, {24'd0, ow_din}, 0);
    endtask

    vec_t vecs[6];
    vec_t va, vb;
    int   d0;

    initial begin
        vecs[0] = '{3'b111, 16'h0550, 16'hFF5E, 2'b00, 32'hFF5E_0550, 2'b11, 2'b00, 1'b0};
        vecs[1] = '{3'b111, 16'h0550, 16'h1234, 2'b10, 32'hFF5E_0550, 2'b11, 2'b10, 1'b0};
        vecs[2] = '{3'b110, 16'h0550, 16'hFF5E, 2'b00, 32'hFF5E_0550, 2'b11, 2'b10, 1'b1};
        vecs[3] = '{3'b101, 16'h0550, 16'h0191, 2'b00, 32'h0191_0550, 2'b10, 2'b01, 1'b0};
        vecs[4] = '{3'b111, 16'hFC90, 16'h07D0, 2'b00, 32'h07D0_FC90, 2'b11, 2'b00, 1'b0};
        vecs[5] = '{3'b111, 16'h0AA2, 16'h0033, 2'b01, 32'h0033_FC90, 2'b11, 2'b01, 1'b0};
        va      = '{3'b111, 16'h0123, 16'h0456, 2'b00, 32'h0456_0123, 2'b11, 2'b00, 1'b0};
        vb      = '{3'b111, 16'h0777, 16'h0888, 2'b00, 32'h0888_0777, 2'b11, 2'b00, 1'b0};
        pres_cfg = 3'b111;

        repeat (3) @(negedge clk);
        check_reset_vals("por");
        ARstN = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", {31'd0, busy}, 0);

        for (int i = 0; i < 6; i++) begin
            load(vecs[i]);
            gap_meas = -1;
            d0 = done_cnt;
            En = 1'b1; @(negedge clk); En = 1'b0;
            wait_done(d0, $sformatf("round%0d", i));
            check_outputs(vecs[i], $sformatf("round%0d", i));
            if (vecs[i].pres[0]) check($sformatf("round%0d_conv_gap", i), gap_meas, CONV);
            else check("nopres_done_gap", {31'd0, (done_gap >= 4 && done_gap <= 6)}, 1);
        end

        // Reset while counting the conversion delay.
        load(va);
        t44_set = 0;
        En = 1'b1; @(negedge clk); En = 1'b0;
        for (int c = 0; c < 500 && !t44_set; c++) @(negedge clk);
        check("cwait_reached", {31'd0, t44_set}, 1);
        repeat (3) @(negedge clk);
        #2 ARstN = 1'b0;
        #1 check_reset_vals("cwait");
        exp_q.delete();
        repeat (4) @(negedge clk);
        load(va);
        t44_set = 0; gap_meas = -1;
        d0 = done_cnt;
        En = 1'b1; ARstN = 1'b1; @(negedge clk); En = 1'b0;
        wait_done(d0, "cwait_restart");
        check_outputs(va, "cwait_restart");
        check("cwait_restart_gap", gap_meas, CONV);

        // Reset during the fifth scratchpad read of sensor 0.
        load(vb);
        En = 1'b1; @(negedge clk); En = 1'b0;
        for (int c = 0; c < 1000 && rd_seen != 5; c++) @(negedge clk);
        check("sread_reached", rd_seen, 5);
        #2 ARstN = 1'b0;
        #1 check_reset_vals("sread");
        exp_q.delete();
        repeat (4) @(negedge clk);
        load(vb);
        d0 = done_cnt;
        En = 1'b1; ARstN = 1'b1; @(negedge clk); En = 1'b0;
        wait_done(d0, "sread_restart");
        check_outputs(vb, "sread_restart");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1);
    end

endmodule
